// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module     : inst_encoder
// Description: RV32I(+M) instruction encoder. Takes decoded fields (op
//              select, rd, rs1, rs2, imm) over valid/ready, packs them into
//              32-bit instruction words and queues them in a DEPTH-entry
//              FIFO. Illegal requests are queued as inst=0 with an illegal
//              flag and latch err_sticky until reset.
//              Optional RV32M encoding is enabled by defining the macro
//              INST_ENCODER_MEXT_EN; without it ops 1A-1E are illegal.
// Revision   : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [31:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_sticky
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_F7_ALT     = 7'b0100000;
`ifdef INST_ENCODER_MEXT_EN
    localparam logic [6:0] C_F7_MULDIV  = 7'b0000001;
`endif

    // Instruction format selects both the bit packing and the immediate rule.
    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_SH = 3'd2,
        FMT_S  = 3'd3,
        FMT_B  = 3'd4,
        FMT_J  = 3'd5,
        FMT_U  = 3'd6
    } fmt_e;

    fmt_e               w_fmt;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [6:0]         w_opc;
    logic               w_op_bad;
    logic               w_imm_ok;
    logic [31:0]        w_enc;
    logic               w_illegal;
    logic [31:0]        w_inst;
    logic signed [31:0] w_simm;
    logic               w_fits_i;
    logic               w_fits_b;
    logic               w_fits_j;
    logic               w_fits_sh;
    logic               w_fits_u;
    logic               w_push;
    logic               w_pop;

    logic [31:0]   r_mem_inst [DEPTH];
    logic          r_mem_ill  [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    // Immediate range checks for each format.
    assign w_simm    = $signed(in_imm);
    assign w_fits_i  = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
    assign w_fits_b  = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !in_imm[0];
    assign w_fits_j  = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !in_imm[0];
    assign w_fits_sh = (in_imm[31:5] == 27'd0);
    assign w_fits_u  = (in_imm[11:0] == 12'd0);

    // Op decode: format, funct3/funct7, opcode, and ops that can never encode.
    always_comb begin
        w_fmt    = FMT_R;
        w_f3     = 3'b000;
        w_f7     = 7'b0000000;
        w_opc    = C_OPC_OP;
        w_op_bad = 1'b0;
        case (in_op)
            5'h00: w_f3 = 3'b000;
            5'h01: begin w_f3 = 3'b000; w_f7 = C_F7_ALT; end
            5'h02: w_f3 = 3'b001;
            5'h03: w_f3 = 3'b010;
            5'h04: w_f3 = 3'b011;
            5'h05: w_f3 = 3'b100;
            5'h06: w_f3 = 3'b101;
            5'h07: begin w_f3 = 3'b101; w_f7 = C_F7_ALT; end
            5'h08: w_f3 = 3'b110;
            5'h09: w_f3 = 3'b111;
            5'h0A: begin w_fmt = FMT_I;  w_opc = C_OPC_OPIMM; w_f3 = 3'b000; end
            5'h0B: begin w_fmt = FMT_I;  w_opc = C_OPC_OPIMM; w_f3 = 3'b010; end
            5'h0C: begin w_fmt = FMT_I;  w_opc = C_OPC_OPIMM; w_f3 = 3'b100; end
            5'h0D: begin w_fmt = FMT_I;  w_opc = C_OPC_OPIMM; w_f3 = 3'b110; end
            5'h0E: begin w_fmt = FMT_I;  w_opc = C_OPC_OPIMM; w_f3 = 3'b111; end
            5'h0F: begin w_fmt = FMT_SH; w_opc = C_OPC_OPIMM; w_f3 = 3'b001; end
            5'h10: begin w_fmt = FMT_SH; w_opc = C_OPC_OPIMM; w_f3 = 3'b101; end
            5'h11: begin w_fmt = FMT_SH; w_opc = C_OPC_OPIMM; w_f3 = 3'b101; w_f7 = C_F7_ALT; end
            5'h12: begin w_fmt = FMT_I;  w_opc = C_OPC_LOAD;   w_f3 = 3'b010; end
            5'h13: begin w_fmt = FMT_S;  w_opc = C_OPC_STORE;  w_f3 = 3'b010; end
            5'h14: begin w_fmt = FMT_B;  w_opc = C_OPC_BRANCH; w_f3 = 3'b000; end
            5'h15: begin w_fmt = FMT_B;  w_opc = C_OPC_BRANCH; w_f3 = 3'b001; end
            5'h16: begin w_fmt = FMT_J;  w_opc = C_OPC_JAL; end
            5'h17: begin w_fmt = FMT_I;  w_opc = C_OPC_JALR;   w_f3 = 3'b000; end
            5'h18: begin w_fmt = FMT_U;  w_opc = C_OPC_LUI; end
            5'h19: begin w_fmt = FMT_U;  w_opc = C_OPC_AUIPC; end
`ifdef INST_ENCODER_MEXT_EN
            5'h1A: begin w_f7 = C_F7_MULDIV; w_f3 = 3'b000; end
            5'h1B: begin w_f7 = C_F7_MULDIV; w_f3 = 3'b100; end
            5'h1C: begin w_f7 = C_F7_MULDIV; w_f3 = 3'b101; end
            5'h1D: begin w_f7 = C_F7_MULDIV; w_f3 = 3'b110; end
            5'h1E: begin w_f7 = C_F7_MULDIV; w_f3 = 3'b111; end
`else
            5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E: w_op_bad = 1'b1;
`endif
            default: w_op_bad = 1'b1;
        endcase
    end

    // Field packing per format; only fields the format uses reach the word.
    always_comb begin
        w_enc    = 32'd0;
        w_imm_ok = 1'b1;
        case (w_fmt)
            FMT_R: begin
                w_enc = {w_f7, in_rs2, in_rs1, w_f3, in_rd, w_opc};
            end
            FMT_I: begin
                w_enc    = {in_imm[11:0], in_rs1, w_f3, in_rd, w_opc};
                w_imm_ok = w_fits_i;
            end
            FMT_SH: begin
                w_enc    = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, w_opc};
                w_imm_ok = w_fits_sh;
            end
            FMT_S: begin
                w_enc    = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_opc};
                w_imm_ok = w_fits_i;
            end
            FMT_B: begin
                w_enc    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                            in_imm[4:1], in_imm[11], w_opc};
                w_imm_ok = w_fits_b;
            end
            FMT_J: begin
                w_enc    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opc};
                w_imm_ok = w_fits_j;
            end
            FMT_U: begin
                w_enc    = {in_imm[31:12], in_rd, w_opc};
                w_imm_ok = w_fits_u;
            end
            default: begin
                w_enc    = 32'd0;
                w_imm_ok = 1'b0;
            end
        endcase
    end

    assign w_illegal = w_op_bad || !w_imm_ok;
    assign w_inst    = w_illegal ? 32'd0 : w_enc;

    // Full blocks input regardless of a same-cycle pop; reset holds it low.
    assign in_ready    = !rst && (r_count != CW'(DEPTH));
    assign out_valid   = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign out_inst    = r_mem_inst[r_rd_ptr];
    assign out_illegal = r_mem_ill[r_rd_ptr];
    assign occupancy   = r_count;
    assign err_sticky  = r_err;

    // FIFO storage, pointers (wrap naturally at power-of-two DEPTH), count, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= 32'd0;
                r_mem_ill[i]  <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_inst[r_wr_ptr] <= w_inst;
                r_mem_ill[r_wr_ptr]  <= w_illegal;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_err <= r_err || (w_push && w_illegal);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_inst_encoder
// Description: Self-checking bench for inst_encoder: directed encodings,
//              full/backpressure, back-to-back streaming, randomized traffic
//              against a field-level reference encoder and queue scoreboard,
//              and mid-stream reset.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op, in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic          out_illegal;
    logic [CW-1:0] occupancy;
    logic          err_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] inst;
        logic        ill;
    } exp_t;
    exp_t q[$];
    logic model_err = 1'b0;

    inst_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_illegal(out_illegal),
        .occupancy(occupancy), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // funct3 of every op, listed straight from the op table.
    function automatic int f3_of(input int op);
        case (op)
            2, 15, 21:              return 1;
            3, 11, 18, 19:          return 2;
            4:                      return 3;
            5, 12, 27:              return 4;
            6, 7, 16, 17, 28:       return 5;
            8, 13, 29:              return 6;
            9, 14, 30:              return 7;
            default:                return 0;
        endcase
    endfunction

    // Reference encoder: returns {illegal, inst}.
    function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
        logic [31:0] u, inst, base, f;
        logic        ill;
        u    = imm;
        ill  = 1'b0;
        inst = 32'd0;
        base = (32'(rs1) << 15) | (32'(rd) << 7);
        f    = 32'(f3_of(op)) << 12;
        if (op <= 9) begin
            inst = ((op == 1 || op == 7) ? 32'h4000_0000 : 32'd0) | (32'(rs2) << 20) | base | f | 32'h33;
        end else if (op <= 14) begin
            ill  = (imm < -2048) || (imm > 2047);
            inst = ((u & 32'hFFF) << 20) | base | f | 32'h13;
        end else if (op <= 17) begin
            ill  = (u > 32'd31);
            inst = ((op == 17) ? 32'h4000_0000 : 32'd0) | (u << 20) | base | f | 32'h13;
        end else if (op == 18) begin
            ill  = (imm < -2048) || (imm > 2047);
            inst = ((u & 32'hFFF) << 20) | base | f | 32'h03;
        end else if (op == 19) begin
            ill  = (imm < -2048) || (imm > 2047);
            inst = (((u >> 5) & 32'd127) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | f
                 | ((u & 32'd31) << 7) | 32'h23;
        end else if (op <= 21) begin
            ill  = (imm < -4096) || (imm > 4094) || u[0];
            inst = (((u >> 12) & 32'd1) << 31) | (((u >> 5) & 32'd63) << 25) | (32'(rs2) << 20)
                 | (32'(rs1) << 15) | f | (((u >> 1) & 32'd15) << 8) | (((u >> 11) & 32'd1) << 7) | 32'h63;
        end else if (op == 22) begin
            ill  = (imm < -1048576) || (imm > 1048574) || u[0];
            inst = (((u >> 20) & 32'd1) << 31) | (((u >> 1) & 32'd1023) << 21) | (((u >> 11) & 32'd1) << 20)
                 | (((u >> 12) & 32'd255) << 12) | (32'(rd) << 7) | 32'h6F;
        end else if (op == 23) begin
            ill  = (imm < -2048) || (imm > 2047);
            inst = ((u & 32'hFFF) << 20) | base | 32'h67;
        end else if (op <= 25) begin
            ill  = (u & 32'hFFF) != 32'd0;
            inst = (u & 32'hFFFF_F000) | (32'(rd) << 7) | ((op == 24) ? 32'h37 : 32'h17);
        end else if (op <= 30) begin
`ifdef INST_ENCODER_MEXT_EN
            inst = 32'h0200_0000 | (32'(rs2) << 20) | base | f | 32'h33;
`else
            ill  = 1'b1;
`endif
        end else begin
            ill = 1'b1;
        end
        if (ill) inst = 32'd0;
        return {ill, inst};
    endfunction

    function automatic void model_push(input int op, input int rd, input int rs1, input int rs2, input int imm);
        logic [32:0] r;
        exp_t e;
        r      = ref_enc(op, rd, rs1, rs2, imm);
        e.inst = r[31:0];
        e.ill  = r[32];
        q.push_back(e);
        model_err = model_err | e.ill;
    endfunction

    task automatic drive_req(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_op    = 5'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = 32'(imm);
        in_valid = 1'b1;
    endtask

    task automatic rand_req(output int op, output int rd, output int rs1, output int rs2, output int imm);
        int bnd [12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                         1048574, 1048576, -1048576, 32};
        op  = int'($urandom_range(0, 31));
        rd  = int'($urandom_range(0, 31));
        rs1 = int'($urandom_range(0, 31));
        rs2 = int'($urandom_range(0, 31));
        case ($urandom_range(0, 6))
            0:       imm = int'($urandom_range(0, 4095)) - 2048;
            1:       imm = bnd[$urandom_range(0, 11)];
            2:       imm = int'($urandom & 32'hFFFF_F000);
            3:       imm = int'($urandom_range(0, 31));
            4:       imm = int'($urandom_range(0, 8191)) - 4096;
            5:       imm = int'($urandom_range(0, 2097151)) - 1048576;
            default: imm = int'($urandom);
        endcase
    endtask

    // Present one request with out_ready low and wait (bounded) for acceptance.
    task automatic push_one(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int t;
        drive_req(op, rd, rs1, rs2, imm);
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_accept: in_ready=%0b after %0d cycles, required 1", in_ready, t);
        end else begin
            @(posedge clk); #1;
            model_push(op, rd, rs1, rs2, imm);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (occupancy !== '0)   begin n_fail++; $display("FAIL reset_occupancy: got %0d required 0", occupancy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_inst !== 32'd0) begin n_fail++; $display("FAIL reset_out_inst: got %h required 0", out_inst); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal: got %b required 0", out_illegal); end
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky: got %b required 0", err_sticky); end
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready_low: got %b required 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready_high: got %b required 1", in_ready); end
    endtask

    task automatic test_directed;
        int          op [8] = '{0, 18, 23, 1, 27, 10, 20, 10};
        int          rd [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int          r1 [8] = '{0, 0, 0, 2, 0, 0, 0, 0};
        int          r2 [8] = '{0, 0, 0, 3, 0, 0, 0, 0};
        int          im [8] = '{0, 0, 96, 0, 0, 2048, 3, 5};
        logic [31:0] ei [8] = '{32'h0000_0033, 32'h0000_2003, 32'h0600_0067, 32'h4031_00B3,
`ifdef INST_ENCODER_MEXT_EN
                                32'h0200_4033,
`else
                                32'h0000_0000,
`endif
                                32'h0, 32'h0, 32'h0050_0093};
        logic        el [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
`ifdef INST_ENCODER_MEXT_EN
                                1'b0,
`else
                                1'b1,
`endif
                                1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            push_one(op[i], rd[i], r1[i], r2[i], im[i]);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: out_valid=%b required 1", i, out_valid); end
            n_checks++; if (out_inst !== ei[i]) begin n_fail++; $display("FAIL dir%0d_inst: got %h required %h", i, out_inst, ei[i]); end
            n_checks++; if (out_illegal !== el[i]) begin n_fail++; $display("FAIL dir%0d_illegal: got %b required %b", i, out_illegal, el[i]); end
            n_checks++; if (err_sticky !== model_err) begin n_fail++; $display("FAIL dir%0d_sticky: got %b required %b", i, err_sticky, model_err); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            void'(q.pop_front());
            n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL dir%0d_drain: occupancy=%0d required 0", i, occupancy); end
        end
    endtask

    task automatic test_full;
        int op, rd, rs1, rs2, imm;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_req(op, rd, rs1, rs2, imm);
            push_one(op, rd, rs1, rs2, imm);
        end
        rand_req(op, rd, rs1, rs2, imm);
        drive_req(op, rd, rs1, rs2, imm);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
        n_checks++; if (occupancy !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_occupancy: got %0d required %0d", occupancy, DEPTH); end
        @(posedge clk); #1;
        n_checks++; if (occupancy !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_hold: got %0d required %0d", occupancy, DEPTH); end
        // Pop while full: the pending request must not slip in on the same edge.
        n_checks++; if (out_inst !== q[0].inst) begin n_fail++; $display("FAIL full_head: got %h required %h", out_inst, q[0].inst); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        void'(q.pop_front());
        n_checks++; if (occupancy !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL full_no_pushthrough: got %0d required %0d", occupancy, DEPTH - 1); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got %b required 1", in_ready); end
        @(posedge clk); #1;
        model_push(op, rd, rs1, rs2, imm);
        in_valid = 1'b0;
        n_checks++; if (occupancy !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_fifth: got %0d required %0d", occupancy, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== q[0].inst || out_illegal !== q[0].ill) begin
                n_fail++;
                $display("FAIL full_drain%0d: got v=%b %h ill=%b required v=1 %h ill=%b",
                         i, out_valid, out_inst, out_illegal, q[0].inst, q[0].ill);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            void'(q.pop_front());
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        int op, rd, rs1, rs2, imm;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_req(op, rd, rs1, rs2, imm);
            drive_req(op, rd, rs1, rs2, imm);
            @(posedge clk); #1;
            if (i > 0) void'(q.pop_front());
            model_push(op, rd, rs1, rs2, imm);
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== q[0].inst || out_illegal !== q[0].ill || occupancy !== CW'(1)) begin
                n_fail++;
                $display("FAIL b2b%0d: got v=%b %h ill=%b occ=%0d required v=1 %h ill=%b occ=1",
                         i, out_valid, out_inst, out_illegal, occupancy, q[0].inst, q[0].ill);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        void'(q.pop_front());
        out_ready = 1'b0;
        n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL b2b_drain: occupancy=%0d required 0", occupancy); end
        n_checks++; if (err_sticky !== model_err) begin n_fail++; $display("FAIL b2b_sticky: got %b required %b", err_sticky, model_err); end
    endtask

    task automatic test_random;
        int  op, rd, rs1, rs2, imm;
        logic wp, wpop;
        op = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 400 + 40; c++) begin
            wp   = in_valid && in_ready;
            wpop = out_valid && out_ready;
            if (wpop) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_underflow: out_valid=1 required 0 (cycle %0d)", c);
                end else if (out_inst !== q[0].inst || out_illegal !== q[0].ill) begin
                    n_fail++;
                    $display("FAIL rnd_head: got %h ill=%b required %h ill=%b (cycle %0d)",
                             out_inst, out_illegal, q[0].inst, q[0].ill, c);
                end
            end
            n_checks++;
            if (occupancy !== CW'(q.size())) begin
                n_fail++;
                $display("FAIL rnd_occupancy: got %0d required %0d (cycle %0d)", occupancy, q.size(), c);
            end
            n_checks++;
            if (err_sticky !== model_err) begin
                n_fail++;
                $display("FAIL rnd_sticky: got %b required %b (cycle %0d)", err_sticky, model_err, c);
            end
            @(posedge clk); #1;
            if (wpop && q.size() > 0) void'(q.pop_front());
            if (wp) model_push(op, rd, rs1, rs2, imm);
            if (c >= 400) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end else begin
                if (!in_valid || wp) begin
                    if ($urandom_range(0, 3) != 0) begin
                        rand_req(op, rd, rs1, rs2, imm);
                        drive_req(op, rd, rs1, rs2, imm);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end
        out_ready = 1'b0;
        n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL rnd_final_drain: occupancy=%0d required 0", occupancy); end
    endtask

    task automatic test_reset_midstream;
        push_one(3, 4, 5, 6, 0);
        push_one(31, 0, 0, 0, 0);
        push_one(24, 7, 0, 0, 32'h1234_5000);
        n_checks++; if (occupancy !== CW'(3)) begin n_fail++; $display("FAIL mid_pre_occupancy: got %0d required 3", occupancy); end
        n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL mid_pre_sticky: got %b required 1", err_sticky); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (occupancy !== '0)    begin n_fail++; $display("FAIL mid_occupancy: got %0d required 0", occupancy); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_sticky: got %b required 0", err_sticky); end
        n_checks++; if (out_inst !== 32'd0)  begin n_fail++; $display("FAIL mid_out_inst: got %h required 0", out_inst); end
        n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL mid_in_ready_low: got %b required 0", in_ready); end
        q.delete();
        model_err = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_in_ready_high: got %b required 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
